// File: rtl/apb_calc_bridge.sv
// APB slave bridging operand/result registers to a calc core; RESULT reads fetch from the core.
// Define APB_CALC_BRIDGE_PSLVERR_EN to report unmapped accesses and RO writes with oPslverr.
module apb_calc_bridge (
  input  logic        iClk,
  input  logic        iRsn,
  input  logic        iPsel,
  input  logic        iPenable,
  input  logic        iPwrite,
  input  logic [7:0]  iPaddr,
  input  logic [31:0] iPwdata,
  output logic [31:0] oPrdata,
  output logic        oPready,
  output logic        oPslverr,
  output logic        oInEnable,
  output logic [31:0] oInA,
  output logic [31:0] oInB,
  output logic        oOutEnable,
  input  logic [31:0] iOutC
);

  // state | meaning
  // IDLE  | zero-wait accesses served; RESULT read access starts the fetch
  // REQ   | oOutEnable high, core computes
  // CAPT  | iOutC latched into result register
  // RESP  | oPready high with captured result
  typedef enum logic [1:0] {IDLE, REQ, CAPT, RESP} state_t;

  localparam logic [5:0] W_A      = 6'd0;
  localparam logic [5:0] W_B      = 6'd1;
  localparam logic [5:0] W_CTRL   = 6'd2;
  localparam logic [5:0] W_RESULT = 6'd3;
  localparam logic [5:0] W_STATUS = 6'd4;

  state_t      state;
  logic [31:0] result;
  logic        valid;
  logic        busy;
  logic [5:0]  word;
  logic        setup_ph;
  logic        access_ph;
  logic        result_rd;
  logic [31:0] rd_data;
  logic        unused_ok;

  assign word      = iPaddr[7:2];
  assign unused_ok = &{1'b0, iPaddr[1:0]};
  assign setup_ph  = iPsel & ~iPenable;
  assign access_ph = iPsel & iPenable;
  assign result_rd = ~iPwrite & (word == W_RESULT);
  assign busy      = (state == REQ) || (state == CAPT);

  // Zero-wait read data is sampled at the setup edge and presented in the access phase.
  always_comb begin
    rd_data = '0;
    if (!iPwrite) begin
      case (word)
        W_A:      rd_data = oInA;
        W_B:      rd_data = oInB;
        W_STATUS: rd_data = {30'b0, busy, valid};
        default:  rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state      <= IDLE;
      result     <= '0;
      valid      <= 1'b0;
      oPrdata    <= '0;
      oPready    <= 1'b0;
      oInEnable  <= 1'b0;
      oOutEnable <= 1'b0;
      oInA       <= '0;
      oInB       <= '0;
    end else begin
      oInEnable  <= 1'b0;
      oOutEnable <= 1'b0;
      if (oPready) begin
        oPready <= 1'b0;
        oPrdata <= '0;
      end
      case (state)
        IDLE: begin
          if (setup_ph && !result_rd) begin
            oPready <= 1'b1;
            oPrdata <= rd_data;
          end
          // Only A, B and CTRL are writable; everything else falls through untouched.
          if (access_ph && oPready && iPwrite) begin
            case (word)
              W_A:    oInA <= iPwdata;
              W_B:    oInB <= iPwdata;
              W_CTRL: if (iPwdata[0]) begin
                oInEnable <= 1'b1;
                valid     <= 1'b0;
              end
              default: ;
            endcase
          end
          if (access_ph && !oPready && result_rd) begin
            state      <= REQ;
            oOutEnable <= 1'b1;
          end
        end
        REQ: state <= iPsel ? CAPT : IDLE;
        CAPT: begin
          result <= iOutC;
          valid  <= 1'b1;
          if (iPsel) begin
            state   <= RESP;
            oPready <= 1'b1;
            oPrdata <= iOutC;
          end else begin
            state <= IDLE;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APB_CALC_BRIDGE_PSLVERR_EN
  logic err;
  assign err = (word > W_STATUS) | (iPwrite & ((word == W_RESULT) | (word == W_STATUS)));

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn)
      oPslverr <= 1'b0;
    else if (state == IDLE && setup_ph && !result_rd)
      oPslverr <= err;
    else
      oPslverr <= 1'b0;
  end
`else
  assign oPslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_calc_bridge.sv
// Directed bench for apb_calc_bridge: transaction-level model plus per-cycle output compare.
module tb_apb_calc_bridge;

  logic        iClk = 1'b0;
  logic        iRsn;
  logic        iPsel, iPenable, iPwrite;
  logic [7:0]  iPaddr;
  logic [31:0] iPwdata;
  logic [31:0] oPrdata;
  logic        oPready, oPslverr, oInEnable, oOutEnable;
  logic [31:0] oInA, oInB;
  logic [31:0] iOutC;

  apb_calc_bridge dut (
    .iClk(iClk), .iRsn(iRsn), .iPsel(iPsel), .iPenable(iPenable), .iPwrite(iPwrite),
    .iPaddr(iPaddr), .iPwdata(iPwdata), .oPrdata(oPrdata), .oPready(oPready),
    .oPslverr(oPslverr), .oInEnable(oInEnable), .oInA(oInA), .oInB(oInB),
    .oOutEnable(oOutEnable), .iOutC(iOutC)
  );

  always #5 iClk = ~iClk;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  bit started  = 1'b0;
  int in_pulses = 0;

  // Model state: register contents and the cycle in which each output event is due.
  logic [31:0] m_a = '0, m_b = '0;
  bit          m_valid = 1'b0;
  logic [31:0] core_val = '0;
  int          exp_ready_cyc = -1, exp_in_cyc = -1, exp_out_cyc = -1;
  logic [31:0] exp_rdata = '0;
  bit          exp_err = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;
  bit          rdy_due;

  always @(posedge iClk) cyc <= cyc + 1;

  // Core returns its value exactly one cycle after the request pulse, garbage otherwise.
  always @(posedge iClk) iOutC <= oOutEnable ? core_val : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge iClk) begin
    if (oInEnable) in_pulses++;
    if (started) begin
      rdy_due = (cyc == exp_ready_cyc);
      chk("pready",     {31'b0, oPready},    {31'b0, rdy_due});
      chk("prdata",     oPrdata,             rdy_due ? exp_rdata : 32'h0);
      chk("pslverr",    {31'b0, oPslverr},   {31'b0, rdy_due & exp_err});
      chk("in_enable",  {31'b0, oInEnable},  {31'b0, cyc == exp_in_cyc});
      chk("out_enable", {31'b0, oOutEnable}, {31'b0, cyc == exp_out_cyc});
      chk("in_a",       oInA,                m_a);
      chk("in_b",       oInB,                m_b);
    end
  end

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata);
    int          waits;
    int          idx;
    bit          mapped, res_rd, eerr;
    logic [31:0] erd;
    idx    = int'(addr[7:2]);
    mapped = (idx <= 4);
    res_rd = !wr && (idx == 3);
`ifdef APB_CALC_BRIDGE_PSLVERR_EN
    eerr = !mapped || (wr && (idx == 3 || idx == 4));
`else
    eerr = 1'b0;
`endif
    waits = res_rd ? 3 : 0;
    erd = '0;
    if (!wr && mapped) begin
      case (idx)
        0: erd = m_a;
        1: erd = m_b;
        3: erd = core_val;
        4: erd = {31'b0, m_valid};
        default: erd = '0;
      endcase
    end
    iPsel = 1; iPenable = 0; iPwrite = wr; iPaddr = addr; iPwdata = wdata;
    @(posedge iClk); #1;
    iPenable = 1;
    exp_ready_cyc = cyc + waits;
    exp_rdata = erd;
    exp_err = eerr;
    if (res_rd) exp_out_cyc = cyc + 1;
    repeat (waits) @(posedge iClk);
    @(negedge iClk);
    last_rdata = oPrdata;
    last_err   = oPslverr;
    @(posedge iClk); #1;
    iPsel = 0; iPenable = 0; iPwrite = 0;
    if (wr && !eerr) begin
      case (idx)
        0: m_a = wdata;
        1: m_b = wdata;
        2: if (wdata[0]) begin exp_in_cyc = cyc; m_valid = 0; end
        default: ;
      endcase
    end
    if (res_rd) m_valid = 1;
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_valid = 0;
    exp_ready_cyc = -1; exp_in_cyc = -1; exp_out_cyc = -1;
  endtask

  int p0;

  initial begin
    iRsn = 0; iPsel = 0; iPenable = 0; iPwrite = 0; iPaddr = '0; iPwdata = '0;
    #1 started = 1;
    #2;
    chk("rst_pready_lit", {31'b0, oPready}, 32'h0);
    chk("rst_in_a_lit", oInA, 32'h0);
    repeat (2) @(posedge iClk);
    #1 iRsn = 1;

    // Operand load and start
    xfer(1, 8'h00, 32'h5A5A_5A5A);
    xfer(1, 8'h04, 32'hA5A5_A5A5);
    xfer(1, 8'h08, 32'h0000_0001);
    chk("in_a_lit", oInA, 32'h5A5A_5A5A);
    chk("in_b_lit", oInB, 32'hA5A5_A5A5);
    xfer(0, 8'h10, 32'h0);
    chk("status_after_start_lit", last_rdata, 32'h0);
    xfer(0, 8'h00, 32'h0);
    xfer(0, 8'h07, 32'h0);
    chk("read_b_lit", last_rdata, 32'hA5A5_A5A5);
    xfer(0, 8'h08, 32'h0);
    chk("ctrl_read_lit", last_rdata, 32'h0);

    // Result fetch
    core_val = 32'hFFFF_FFFF;
    xfer(0, 8'h0C, 32'h0);
    chk("result_lit", last_rdata, 32'hFFFF_FFFF);
    xfer(0, 8'h10, 32'h0);
    chk("status_valid_lit", last_rdata, 32'h1);

    // CTRL without START leaves VALID; back-to-back STARTs give two pulses
    xfer(1, 8'h08, 32'hFFFF_FFFE);
    xfer(0, 8'h10, 32'h0);
    p0 = in_pulses;
    xfer(1, 8'h08, 32'h0000_0003);
    xfer(1, 8'h08, 32'h8000_0001);
    repeat (2) @(posedge iClk);
    #1 chk("b2b_pulses_lit", in_pulses - p0, 32'd2);

    core_val = 32'h1357_9BDF;
    xfer(0, 8'h0C, 32'h0);
    xfer(0, 8'h10, 32'h0);
    xfer(1, 8'h08, 32'h1);

    // Abandon a RESULT read during REQ
    iPsel = 1; iPenable = 0; iPwrite = 0; iPaddr = 8'h0C;
    @(posedge iClk); #1;
    iPenable = 1; exp_out_cyc = cyc + 1; exp_ready_cyc = -1;
    @(posedge iClk); #1;
    iPsel = 0; iPenable = 0;
    repeat (4) @(posedge iClk);
    #1 xfer(0, 8'h10, 32'h0);
    chk("status_after_drop_lit", last_rdata, 32'h0);

    // Unmapped read and RO write
    xfer(0, 8'h20, 32'h0);
`ifdef APB_CALC_BRIDGE_PSLVERR_EN
    chk("unmapped_err_lit", {31'b0, last_err}, 32'h1);
`else
    chk("unmapped_err_lit", {31'b0, last_err}, 32'h0);
`endif
    chk("unmapped_data_lit", last_rdata, 32'h0);
    xfer(1, 8'h0C, 32'h0000_1234);
`ifdef APB_CALC_BRIDGE_PSLVERR_EN
    chk("ro_write_err_lit", {31'b0, last_err}, 32'h1);
`else
    chk("ro_write_err_lit", {31'b0, last_err}, 32'h0);
`endif
    xfer(1, 8'h14, 32'hFFFF_FFFF);
    xfer(0, 8'h10, 32'h0);

    // Reset asserted while the FSM is in CAPT
    core_val = 32'h0BAD_F00D;
    iPsel = 1; iPenable = 0; iPwrite = 0; iPaddr = 8'h0C;
    @(posedge iClk); #1;
    iPenable = 1; exp_out_cyc = cyc + 1; exp_ready_cyc = -1;
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    iRsn = 0;
    model_reset();
    #1;
    chk("rst_capt_pready_lit", {31'b0, oPready}, 32'h0);
    chk("rst_capt_in_a_lit", oInA, 32'h0);
    iPsel = 0; iPenable = 0;
    @(posedge iClk); #1;
    iRsn = 1;
    xfer(0, 8'h10, 32'h0);
    chk("status_after_rst_lit", last_rdata, 32'h0);
    xfer(1, 8'h00, 32'h0000_0011);
    chk("first_write_after_rst_lit", oInA, 32'h0000_0011);

    repeat (3) @(posedge iClk);
    #1 started = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
